data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Memory-side responder for the CPU's data port. It accepts one load/store request at a time over a valid/ready handshake and adds a programmable number of wait states. Requests are served from an internal word-addressed RAM or a small memory-mapped I/O (MMIO) register window. It sits between the CPU data interface (address, write data, write enable, read data) and the board-level outputs (GPIO).

Parameters:
DEPTH, 256, number of 16-bit RAM words; power of two, at most 32768; RAM occupies addresses 0..DEPTH-1.
LATENCY, 2, wait states inserted between request acceptance and response; range 0..15.
MMIO_BASE, 16'hFF00, base address of the MMIO window.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  CPU request pending; addr/wdata/we must stay stable until rsp_ready
req_we  input  1  1 = store, 0 = load
req_addr  input  16  word address
req_wdata  input  16  store data
rsp_ready  output  1  one-cycle pulse marking request completion
rsp_rdata  output  16  load data; valid in the rsp_ready cycle, held until the next completion
rsp_err  output  1  unmapped access; valid with rsp_ready
gpio_out  output  16  MMIO GPIO register contents
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, rsp_ready=0, rsp_rdata=0, rsp_err=0, gpio_out=0, cycle counter=0, sticky error=0.
- RAM contents are not reset.
- FSM states:
  - IDLE: when req_valid=1, capture addr/we/wdata, load wait counter=LATENCY, go to WAIT; if LATENCY=0, go directly to RESP.
  - WAIT: decrement the wait counter; when it reaches 1 (i.e. after LATENCY cycles in WAIT), go to RESP.
  - RESP: rsp_ready=1 for exactly one cycle, then go to IDLE.
- Commit timing: the store is performed, and load data captured into rsp_rdata, on the clock edge that enters RESP.
- Latency: acceptance edge to rsp_ready high is LATENCY+1 cycles.
- Throughput: minimum LATENCY+2 cycles per request.
- A request held high through RESP is treated as already served; a new request is sampled only in IDLE on the cycle after RESP.
- The CPU must deassert req_valid or present a new request in the cycle after rsp_ready.
- Address decode:
  - addr < DEPTH: RAM.
  - MMIO_BASE+0: CYCLE, a free-running 16-bit counter.
    - Increments every cycle and wraps 16'hFFFF -> 0.
    - A store loads it with wdata; the load wins over the increment on that edge.
  - MMIO_BASE+1: GPIO, read/write; drives gpio_out.
  - MMIO_BASE+2: STATUS, read-only; bit0 = sticky error, bit1 = busy; other bits read 0.
    - A store to STATUS with wdata[0]=1 clears the sticky error.
    - Any other store to STATUS is ignored.
  - All other addresses (DEPTH..MMIO_BASE-1, MMIO_BASE+3..16'hFFFF):
    - Load returns 0; store is ignored.
    - rsp_err=1 in the RESP cycle and the sticky error is set.
- rsp_err is 0 in every cycle that is not RESP.
- Reset mid-transaction: aborts immediately. A store not yet committed is not performed; no rsp_ready is issued.
- req_addr/req_wdata/req_we are captured at acceptance; later changes are ignored.

Decomposition:
- Shared package makina_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - MMIO offset constants CYCLE_OFS=0, GPIO_OFS=1, STATUS_OFS=2;
  - STATUS bit positions.
- One sub-module, mem_mmio_regs, holds the CYCLE/GPIO/STATUS registers and their read mux. It takes a commit strobe, offset, we, wdata and busy, and returns rdata, gpio_out and a hit flag.
- The RAM array, address decode and FSM stay in the top module.

Test Plan:
1. LATENCY=2, store 16'hBEEF to addr 5, then load addr 5 -> each rsp_ready pulses exactly 3 cycles after acceptance; load returns 16'hBEEF, rsp_err=0.
2. LATENCY=0, back-to-back stores to 0..3 followed by loads -> rsp_ready every 2nd cycle; loads return the written data in order.
3. Store 16'h00A5 to 16'hFF01 -> gpio_out=16'h00A5 from the edge entering RESP; load 16'hFF01 returns 16'h00A5.
4. Store 16'hFFFE to 16'hFF00, load it 5 cycles later -> value has wrapped past 16'hFFFF to a small count, consistent with exact cycle timing.
5. Load from 16'h1000 (DEPTH=256) -> rdata=0, rsp_err=1 with rsp_ready; STATUS reads bit0=1; storing 1 to STATUS clears it to 0.
6. Store to addr 7 with rst asserted during WAIT -> no rsp_ready; busy=0; gpio_out=0; a subsequent write of a new value to addr 7 followed by a load returns that new value (the aborted store did not commit).

Source files
------------

// File: rtl/makina_mem_pkg.sv
// Shared definitions for the CPU data-port memory responder.
// Holds the responder FSM state encoding, the MMIO register offsets
// within the MMIO window and the bit positions of the STATUS register.
package makina_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] CYCLE_OFS  = 2'd0;
  localparam logic [1:0] GPIO_OFS   = 2'd1;
  localparam logic [1:0] STATUS_OFS = 2'd2;

  localparam int STATUS_ERR_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 1;

endpackage

// File: rtl/mem_mmio_regs.sv
// MMIO register block: CYCLE counter, GPIO register and STATUS register.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   commit_i       strobe on the edge that completes a non-RAM access
//   we_i           1 = store
//   ofs_i          address offset relative to the MMIO window base
//   wdata_i        store data
//   busy_i         responder busy flag, reported in STATUS
//   err_set_i      access is unmapped; set the sticky error on commit
//   rdata_o        read mux output for ofs_i
//   gpio_o         GPIO register contents
//   hit_o          ofs_i selects one of the three registers
module mem_mmio_regs
  import makina_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_i,
  input  logic        we_i,
  input  logic [15:0] ofs_i,
  input  logic [15:0] wdata_i,
  input  logic        busy_i,
  input  logic        err_set_i,
  output logic [15:0] rdata_o,
  output logic [15:0] gpio_o,
  output logic        hit_o
);

  logic [15:0] cycle_q, cycle_d;
  logic [15:0] gpio_q, gpio_d;
  logic        err_q, err_d;

  assign hit_o  = (ofs_i < 16'd3);
  assign gpio_o = gpio_q;

  always_comb begin
    // The counter free-runs; a store to CYCLE overrides the increment.
    cycle_d = cycle_q + 16'd1;
    gpio_d  = gpio_q;
    err_d   = err_q;
    if (commit_i) begin
      if (err_set_i) begin
        err_d = 1'b1;
      end else if (we_i && hit_o) begin
        case (ofs_i[1:0])
          CYCLE_OFS:  cycle_d = wdata_i;
          GPIO_OFS:   gpio_d  = wdata_i;
          STATUS_OFS: if (wdata_i[STATUS_ERR_BIT]) err_d = 1'b0;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (hit_o) begin
      case (ofs_i[1:0])
        CYCLE_OFS:  rdata_o = cycle_q;
        GPIO_OFS:   rdata_o = gpio_q;
        STATUS_OFS: begin
          rdata_o[STATUS_ERR_BIT]  = err_q;
          rdata_o[STATUS_BUSY_BIT] = busy_i;
        end
        default:    rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      gpio_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      gpio_q  <= gpio_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port. Accepts one load/store at a
// time, inserts LATENCY wait states, then pulses rsp_ready for one cycle.
// Accesses go to an internal word RAM (0..DEPTH-1) or to the MMIO window at
// MMIO_BASE (CYCLE, GPIO, STATUS); anything else is flagged with rsp_err.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_valid      request pending (addr/wdata/we stable until rsp_ready)
//   req_we         1 = store, 0 = load
//   req_addr       word address
//   req_wdata      store data
//   rsp_ready      one-cycle completion pulse
//   rsp_rdata      load data, held until the next load completes
//   rsp_err        unmapped access, valid with rsp_ready
//   gpio_out       GPIO register contents
//   busy           FSM is not in IDLE
module data_mem_responder
  import makina_mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] gpio_out,
  output logic        busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [3:0]  LAT_L   = 4'(LATENCY);

  logic [15:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, wdata_q;
  logic        we_q;
  logic [15:0] rdata_q;
  logic        err_q;

  logic [15:0] cur_addr, cur_wdata, mmio_rdata;
  logic        cur_we, commit, ram_hit, regs_hit, mmio_hit, unmapped;

  // With LATENCY=0 the access commits on the acceptance edge itself, so the
  // live request is used in IDLE and the captured copy afterwards.
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;

  assign commit = ((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1));

  assign ram_hit  = ({1'b0, cur_addr} < DEPTH_L);
  // Guard against the offset subtraction wrapping for addresses below the base.
  assign mmio_hit = !ram_hit && (cur_addr >= MMIO_BASE) && regs_hit;
  assign unmapped = !ram_hit && !mmio_hit;

  mem_mmio_regs u_regs (
    .clk       (clk),
    .rst       (rst),
    .commit_i  (commit && !ram_hit),
    .we_i      (cur_we),
    .ofs_i     (cur_addr - MMIO_BASE),
    .wdata_i   (cur_wdata),
    .busy_i    (busy),
    .err_set_i (unmapped),
    .rdata_o   (mmio_rdata),
    .gpio_o    (gpio_out),
    .hit_o     (regs_hit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = LAT_L;
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q <= unmapped;
        if (!cur_we) begin
          rdata_q <= ram_hit  ? mem[cur_addr[AW-1:0]] :
                     mmio_hit ? mmio_rdata : 16'h0000;
        end
      end
    end
  end

  // Request capture and RAM contents carry no reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
    end
    if (commit && cur_we && ram_hit) begin
      mem[cur_addr[AW-1:0]] <= cur_wdata;
    end
  end

  assign rsp_ready = (state_q == RESP);
  assign rsp_err   = rsp_ready && err_q;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: LATENCY=2, instance B: LATENCY=0
  logic        va, wea, vb, web;
  logic [15:0] aa, da, ab, db;
  logic        ra, ea, ba, rb, eb, bb;
  logic [15:0] rda, ga, rdb, gb;

  data_mem_responder #(.DEPTH(256), .LATENCY(2), .MMIO_BASE(16'hFF00)) uA (
    .clk(clk), .rst(rst), .req_valid(va), .req_we(wea), .req_addr(aa),
    .req_wdata(da), .rsp_ready(ra), .rsp_rdata(rda), .rsp_err(ea),
    .gpio_out(ga), .busy(ba));

  data_mem_responder #(.DEPTH(256), .LATENCY(0), .MMIO_BASE(16'hFF00)) uB (
    .clk(clk), .rst(rst), .req_valid(vb), .req_we(web), .req_addr(ab),
    .req_wdata(db), .rsp_ready(rb), .rsp_rdata(rdb), .rsp_err(eb),
    .gpio_out(gb), .busy(bb));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request from an IDLE-cycle negedge, wait (bounded) for
  // rsp_ready, then step one more cycle so the FSM is back in IDLE.
  task automatic xfer(input bit sel, input logic we, input logic [15:0] a,
                      input logic [15:0] d, output logic [15:0] rd,
                      output logic er, output logic [15:0] g,
                      output int cyc, output logic rdy_after);
    if (!sel) begin va = 1'b1; wea = we; aa = a; da = d; end
    else      begin vb = 1'b1; web = we; ab = a; db = d; end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sel ? rb : ra) && cyc < 40);
    rd = sel ? rdb : rda;
    er = sel ? eb : ea;
    g  = sel ? gb : ga;
    va = 1'b0;
    vb = 1'b0;
    @(negedge clk);
    rdy_after = sel ? rb : ra;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] rd;
    logic        err;
    logic [15:0] gpio;
  } vec_t;

  vec_t tbl [17];

  logic [15:0] rd, g;
  logic        er, rdy2;
  int          cyc;

  initial begin
    tbl[0]  = '{1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 16'h00FF, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000};
    tbl[5]  = '{1'b1, 16'hFF01, 16'h00A5, 1'b0, 16'h0000, 1'b0, 16'h00A5};
    tbl[6]  = '{1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h00A5, 1'b0, 16'h00A5};
    tbl[7]  = '{1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h0003, 1'b0, 16'h00A5};
    tbl[8]  = '{1'b1, 16'hFF02, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h00A5};
    tbl[9]  = '{1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h0003, 1'b0, 16'h00A5};
    tbl[10] = '{1'b1, 16'hFF02, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h00A5};
    tbl[11] = '{1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h00A5};
    tbl[12] = '{1'b1, 16'hFF03, 16'h1111, 1'b0, 16'h0000, 1'b1, 16'h00A5};
    tbl[13] = '{1'b0, 16'hFEFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h00A5};
    tbl[14] = '{1'b1, 16'hFF02, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h00A5};
    tbl[15] = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h00A5};
    tbl[16] = '{1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h00A5, 1'b0, 16'h00A5};

    rst = 1'b1;
    va = 1'b0; wea = 1'b0; aa = '0; da = '0;
    vb = 1'b0; web = 1'b0; ab = '0; db = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset rsp_ready", {15'b0, ra}, 16'h0000);
    chk("reset rsp_rdata", rda, 16'h0000);
    chk("reset rsp_err",   {15'b0, ea}, 16'h0000);
    chk("reset gpio_out",  ga, 16'h0000);
    chk("reset busy",      {15'b0, ba}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven accesses on the LATENCY=2 instance
    for (int i = 0; i < 17; i++) begin
      xfer(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, g, cyc, rdy2);
      chk($sformatf("A[%0d] latency", i), 16'(cyc), 16'd3);
      chk($sformatf("A[%0d] rsp_err", i), {15'b0, er}, {15'b0, tbl[i].err});
      chk($sformatf("A[%0d] gpio_out", i), g, tbl[i].gpio);
      chk($sformatf("A[%0d] ready one-shot", i), {15'b0, rdy2}, 16'h0000);
      if (tbl[i].chk_rd) chk($sformatf("A[%0d] rdata", i), rd, tbl[i].rd);
    end

    // CYCLE wrap: store FFFE commits on edge Es; load commits on Es+4 and
    // sees the value from before that edge: FFFE + 3 = 0001.
    xfer(1'b0, 1'b1, 16'hFF00, 16'hFFFE, rd, er, g, cyc, rdy2);
    chk("cycle store err", {15'b0, er}, 16'h0000);
    xfer(1'b0, 1'b0, 16'hFF00, 16'h0000, rd, er, g, cyc, rdy2);
    chk("cycle wrap rdata", rd, 16'h0001);

    // LATENCY=0 back-to-back: every request completes in two cycles
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b1, 16'(i), 16'hA000 + 16'(i * 16'h0111), rd, er, g, cyc, rdy2);
      chk($sformatf("B store %0d latency", i), 16'(cyc), 16'd1);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b0, 16'(i), 16'h0000, rd, er, g, cyc, rdy2);
      chk($sformatf("B load %0d latency", i), 16'(cyc), 16'd1);
      chk($sformatf("B load %0d rdata", i), rd, 16'hA000 + 16'(i * 16'h0111));
    end
    // With no wait states the STATUS load commits from IDLE, so busy reads 0
    xfer(1'b1, 1'b0, 16'hFF02, 16'h0000, rd, er, g, cyc, rdy2);
    chk("B status rdata", rd, 16'h0000);
    chk("B status err", {15'b0, er}, 16'h0000);

    // Reset in the middle of a store on instance A
    xfer(1'b0, 1'b1, 16'h0007, 16'h1111, rd, er, g, cyc, rdy2);
    va = 1'b1; wea = 1'b1; aa = 16'h0007; da = 16'h2222;
    @(negedge clk);
    chk("mid busy before rst", {15'b0, ba}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("abort rsp_ready", {15'b0, ra}, 16'h0000);
    chk("abort busy",      {15'b0, ba}, 16'h0000);
    chk("abort gpio_out",  ga, 16'h0000);
    va = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort no ready %0d", i), {15'b0, ra}, 16'h0000);
    end
    xfer(1'b0, 1'b0, 16'h0007, 16'h0000, rd, er, g, cyc, rdy2);
    chk("aborted store not committed", rd, 16'h1111);
    xfer(1'b0, 1'b1, 16'h0007, 16'h3333, rd, er, g, cyc, rdy2);
    xfer(1'b0, 1'b0, 16'h0007, 16'h0000, rd, er, g, cyc, rdy2);
    chk("post-reset store/load", rd, 16'h3333);
    chk("post-reset latency", 16'(cyc), 16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
